sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- MEM-stage controller sitting directly downstream of the EXE-stage ALU.
- Takes the ALU result as the byte address of LDR/STR and the store value, and performs a 32-bit access on an external 16-bit-wide SRAM as two half-word phases.
- Drives `ready` low to freeze the pipeline until the access completes.
- Returns the 32-bit load data to the MEM/WB register.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM half-word 0.
- SRAM_AW, 18: SRAM half-word address width.
- ACCESS_CYCLES, 2: cycles per half-word phase; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- mem_r_en  input  1  load request (LDR in MEM stage).
- mem_w_en  input  1  store request (STR in MEM stage).
- alu_res  input  32  byte address from ALU.
- st_val  input  32  store data.
- ready  output  1  0 = freeze pipeline; 1 = MEM stage may advance.
- read_data  output  32  load result.
- sram_addr  output  SRAM_AW  SRAM half-word address.
- sram_dq_o  output  16  write data to SRAM.
- sram_dq_i  input  16  read data from SRAM.
- sram_dq_oe  output  1  1 = controller drives the data bus.
- sram_we_n  output  1  SRAM write enable, active-low.

Behaviour:
- **Address mapping:** `w = (alu_res - ADDR_BASE) >> 2`, computed 32-bit and truncated. Low half-word goes to `{w[SRAM_AW-2:0],1'b0}`, high half-word to `{w[SRAM_AW-2:0],1'b1}`. `alu_res[1:0]` is ignored. Addresses below ADDR_BASE wrap modulo 2^SRAM_AW; no error is raised.
- **FSM states:** IDLE, LOW, HIGH, DONE. A phase counter runs 0..ACCESS_CYCLES-1 in LOW and HIGH.
- **IDLE:**
  - `mem_r_en | mem_w_en` -> LOW, counter = 0.
  - Request and address are latched on that edge; later input changes are ignored until IDLE is re-entered.
  - Both enables high -> treated as a store.
- **LOW:** `sram_addr` = low address. On counter = ACCESS_CYCLES-1 -> HIGH, counter = 0.
- **HIGH:** `sram_addr` = high address. On counter = ACCESS_CYCLES-1 -> DONE.
- **DONE:** one cycle, then -> IDLE unconditionally. A request held in the following IDLE cycle is a new access.
- **ready (combinational):**
  - 1 in IDLE with no request, and in DONE.
  - 0 in IDLE with a request, in LOW, and in HIGH.
- **Latency:** request first seen in cycle 0 -> ready = 1 in cycle 2·ACCESS_CYCLES+1. Default: cycle 5.
- **Write timing (per phase):**
  - `sram_dq_oe` = 1 for the whole phase.
  - `sram_dq_o` = `st_val[15:0]` in LOW, `st_val[31:16]` in HIGH.
  - `sram_we_n` = 1 in the first cycle of a phase and 0 for the remaining ACCESS_CYCLES-1 cycles, so address and data have one setup cycle.
- **Read timing:** `sram_we_n` = 1 and `sram_dq_oe` = 0. `sram_dq_i` is sampled on the clock edge that ends each phase into the low/high half of `read_data`.
- **read_data:** valid from DONE and held until the next load overwrites it; stores do not change it.
- **Idle bus:** `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_addr` = 0, `sram_dq_o` = 0.
- **Reset values (any state, immediately on reset assert):** state IDLE, counter 0, `read_data` 0, `sram_we_n` 1, `sram_dq_oe` 0, `sram_addr` 0, `sram_dq_o` 0. `ready` follows the IDLE rule.
- **Request dropped mid-access:** the access still completes; `ready` is don't-care to the pipeline.

Optional Feature:
- **Macro:** SRAM_LAST_READ_HIT_EN.
- **Defined:**
  - One-entry tag register: last loaded word index `w` plus a valid bit. Reset clears valid.
  - A load in IDLE whose `w` matches a valid tag goes IDLE -> DONE directly, with no SRAM activity. `ready` = 0 in the request cycle and 1 in the next; `read_data` is unchanged.
  - A completed load sets the tag and valid.
  - A store to the tagged `w` clears valid; a store to any other address leaves the tag intact.
- **Undefined:** no tag logic; every load takes the full 2·ACCESS_CYCLES+1 cycles.

Test Plan:
- **Store mapping:** store `alu_res`=1028, `st_val`=0xDEADBEEF -> writes 0xBEEF at sram_addr 2, then 0xDEAD at sram_addr 3. `sram_we_n` is low only in the second cycle of each phase; ready rises in cycle 5.
- **Load:** load `alu_res`=1028 with the SRAM model holding the above -> `read_data`=0xDEADBEEF in DONE (cycle 5); ready 0 in cycles 0-4.
- **Both enables:** both high, `alu_res`=1024, `st_val`=0x00010002 -> store executes (0x0002 at addr 0, 0x0001 at addr 1); `read_data` unchanged.
- **Address wrap:** load `alu_res`=1020 -> `sram_addr` = 2^18-2 then 2^18-1.
- **Reset mid-access:** assert reset during HIGH of a store -> `sram_we_n`=1, `sram_dq_oe`=0 and state IDLE immediately. After release with no request -> ready=1.
- **Optional feature (SRAM_LAST_READ_HIT_EN):** two loads of 1028 -> second has ready=1 in cycle 1 with no SRAM activity. Store to 1028 then load 1028 -> full 5-cycle access.

Source files
------------

// File: rtl/sram_mem_controller.sv
// MEM-stage controller: 32-bit LDR/STR as two half-word phases on a 16-bit SRAM.
// Optional last-read-hit bypass enabled by defining SRAM_LAST_READ_HIT_EN.
module sram_mem_controller #(
  parameter logic [31:0] ADDR_BASE     = 32'd1024,
  parameter int unsigned SRAM_AW       = 18,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        st_val,
  output logic               ready,
  output logic [31:0]        read_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int unsigned WI_W  = SRAM_AW - 1;
  localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             is_store;
  logic [WI_W-1:0]  widx_q;
  logic [31:0]      st_q;
  logic [15:0]      rd_lo;

  logic             req;
  logic             hit;
  logic [WI_W-1:0]  widx;
  logic             nx_store;
  logic [WI_W-1:0]  nx_widx;
  logic [31:0]      nx_st;
  logic             rd_lo_end;
  logic             rd_hi_end;

  // Word index of the incoming address; wraps modulo the SRAM size.
  assign widx = WI_W'((alu_res - ADDR_BASE) >> 2);
  assign req  = mem_r_en | mem_w_en;

  assign rd_lo_end = (state == LOW)  && (cnt == CNT_LAST) && !is_store;
  assign rd_hi_end = (state == HIGH) && (cnt == CNT_LAST) && !is_store;

`ifdef SRAM_LAST_READ_HIT_EN
  logic            tag_valid;
  logic [WI_W-1:0] tag;

  assign hit = mem_r_en && !mem_w_en && tag_valid && (tag == widx);

  // One-entry tag of the last completed load; a store to that word invalidates it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid <= 1'b0;
      tag       <= '0;
    end else if (rd_hi_end) begin
      tag_valid <= 1'b1;
      tag       <= widx_q;
    end else if ((state == IDLE) && mem_w_en && (widx == tag)) begin
      tag_valid <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign ready = (state == DONE) || ((state == IDLE) && !req);

  // Next state / counter, plus the request view seen by the next cycle's bus outputs.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    nx_store = is_store;
    nx_widx  = widx_q;
    nx_st    = st_q;
    case (state)
      IDLE: begin
        nx_store = mem_w_en;
        nx_widx  = widx;
        nx_st    = st_val;
        if (req) begin
          state_d = hit ? DONE : LOW;
          cnt_d   = '0;
        end
      end
      LOW: begin
        if (cnt == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered SRAM bus; first cycle of a phase is write setup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_store   <= 1'b0;
      widx_q     <= '0;
      st_q       <= '0;
      rd_lo      <= '0;
      read_data  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if ((state == IDLE) && req) begin
        is_store <= mem_w_en;
        widx_q   <= widx;
        st_q     <= st_val;
      end
      if (rd_lo_end) rd_lo <= sram_dq_i;
      if (rd_hi_end) read_data <= {sram_dq_i, rd_lo};
      case (state_d)
        LOW: begin
          sram_addr  <= {nx_widx, 1'b0};
          sram_dq_o  <= nx_st[15:0];
          sram_dq_oe <= nx_store;
          sram_we_n  <= !(nx_store && (cnt_d != '0));
        end
        HIGH: begin
          sram_addr  <= {nx_widx, 1'b1};
          sram_dq_o  <= nx_st[31:16];
          sram_dq_oe <= nx_store;
          sram_we_n  <= !(nx_store && (cnt_d != '0));
        end
        default: begin
          sram_addr  <= '0;
          sram_dq_o  <= '0;
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller: expected SRAM writes and load data are
// queued when an access is issued and compared as the controller produces them.
module tb_sram_mem_controller;

  localparam int FULL_LAT = 5;
`ifdef SRAM_LAST_READ_HIT_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 5;
`endif

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic        ready;
  logic [31:0] read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] rd_hold;
  logic [33:0] wr_exp;
  logic [15:0] sram_mem[16];

  sram_mem_controller dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .alu_res   (alu_res),
    .st_val    (st_val),
    .ready     (ready),
    .read_data (read_data),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_i (sram_dq_i),
    .sram_dq_oe(sram_dq_oe),
    .sram_we_n (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small SRAM model; only addresses 0..3 and 2^18-2..2^18-1 are used, so 4 bits suffice.
  assign sram_dq_i = sram_dq_oe ? 16'h0000 : sram_mem[sram_addr[3:0]];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[3:0]] <= sram_dq_o;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: each strobed half-word must match the head of the write queue.
  always @(negedge clk) begin
    if (rst && !sram_we_n) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", {14'd0, sram_addr, sram_dq_o}, 64'd0);
      end else begin
        wr_exp = wr_q.pop_front();
        check("wr_addr", 64'(sram_addr), 64'(wr_exp[33:16]));
        check("wr_data", 64'(sram_dq_o), 64'(wr_exp[15:0]));
        check("wr_oe", 64'(sram_dq_oe), 64'd1);
      end
    end
  end

  // Issue one access at posedge+1 and follow it until ready, checking per-cycle bus pattern.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] val, input int exp_lat,
                            input logic [17:0] exp_lo, input logic [17:0] exp_hi,
                            input logic [31:0] exp_rd, input logic scramble);
    int c;
    logic done;
    logic [7:0] we_v, oe_v, we_e, oe_e, mask;
    logic [17:0] a1, a3;
    mem_r_en = rd;
    mem_w_en = wr;
    alu_res  = addr;
    st_val   = val;
    if (wr) begin
      wr_q.push_back({exp_lo, val[15:0]});
      wr_q.push_back({exp_hi, val[31:16]});
    end else begin
      rd_q.push_back(exp_rd);
    end
    we_v = '0; oe_v = '0; a1 = '0; a3 = '0; c = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (c < 8) begin
        we_v[c] = sram_we_n;
        oe_v[c] = sram_dq_oe;
      end
      if (c == 1) a1 = sram_addr;
      if (c == 3) a3 = sram_addr;
      if (c == 0) check("ready_in_req_cycle", 64'(ready), 64'd0);
      if (ready && (c > 0)) begin
        done = 1'b1;
      end else if (c >= 40) begin
        check("ready_timeout", 64'd1, 64'd0);
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        c++;
        if (scramble) begin
          alu_res = 32'h0000_1ffc;
          st_val  = $urandom;
        end
      end
    end
    check("latency", 64'(c), 64'(exp_lat));
    we_e = '1; oe_e = '0;
    for (int i = 0; i < 8; i++) begin
      if (i <= exp_lat) begin
        we_e[i] = !(wr && (i == 2 || i == 4));
        oe_e[i] = wr && (i >= 1) && (i <= 4);
      end
    end
    mask = 8'((9'd1 << (exp_lat + 1)) - 9'd1);
    check("we_n_pattern", 64'(we_v & mask), 64'(we_e & mask));
    check("oe_pattern", 64'(oe_v & mask), 64'(oe_e & mask));
    if (exp_lat == FULL_LAT) begin
      check("addr_low_phase", 64'(a1), 64'(exp_lo));
      check("addr_high_phase", 64'(a3), 64'(exp_hi));
    end else begin
      check("addr_hit_idle", 64'(a1), 64'd0);
    end
    check("done_bus_idle", {29'd0, sram_dq_oe, sram_addr, sram_dq_o}, 64'd0);
    if (!wr) begin
      rd_hold = rd_q.pop_front();
      check("read_data", 64'(read_data), 64'(rd_hold));
    end else begin
      check("read_data_held", 64'(read_data), 64'(rd_hold));
    end
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) sram_mem[i] = 16'h0000;
    rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = '0; st_val = '0;
    rd_hold = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_read_data", 64'(read_data), 64'd0);
    check("rst_we_n", 64'(sram_we_n), 64'd1);
    check("rst_oe", 64'(sram_dq_oe), 64'd0);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_dq_o", 64'(sram_dq_o), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_access(1'b0, 1'b1, 32'd1028, 32'hdead_beef, FULL_LAT, 18'd2, 18'd3, 32'h0, 1'b0);
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, FULL_LAT, 18'd2, 18'd3, 32'hdead_beef, 1'b0);
    run_access(1'b1, 1'b1, 32'd1024, 32'h0001_0002, FULL_LAT, 18'd0, 18'd1, 32'h0, 1'b0);
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, FULL_LAT, 18'd0, 18'd1, 32'h0001_0002, 1'b0);
    run_access(1'b0, 1'b1, 32'd1020, 32'hcafe_1234, FULL_LAT, 18'h3fffe, 18'h3ffff, 32'h0, 1'b0);
    run_access(1'b1, 1'b0, 32'd1020, 32'h0, FULL_LAT, 18'h3fffe, 18'h3ffff, 32'hcafe_1234, 1'b0);
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, FULL_LAT, 18'd2, 18'd3, 32'hdead_beef, 1'b1);
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, HIT_LAT, 18'd2, 18'd3, 32'hdead_beef, 1'b0);
    run_access(1'b0, 1'b1, 32'd1028, 32'h1111_2222, FULL_LAT, 18'd2, 18'd3, 32'h0, 1'b0);
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, FULL_LAT, 18'd2, 18'd3, 32'h1111_2222, 1'b0);

    // Reset in the high phase of a store: only the low half-word reaches the SRAM.
    mem_w_en = 1'b1;
    alu_res  = 32'd1028;
    st_val   = 32'h5555_6666;
    wr_q.push_back({18'd2, 16'h6666});
    repeat (4) @(negedge clk);
    check("rst_mid_hi_addr", 64'(sram_addr), 64'd3);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_we_n", 64'(sram_we_n), 64'd1);
    check("rst_mid_oe", 64'(sram_dq_oe), 64'd0);
    check("rst_mid_addr", 64'(sram_addr), 64'd0);
    check("rst_mid_read_data", 64'(read_data), 64'd0);
    check("rst_mid_ready_req", 64'(ready), 64'd0);
    mem_w_en = 1'b0;
    #1;
    check("rst_mid_ready_idle", 64'(ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    rd_hold = '0;
    @(negedge clk);
    check("post_rst_ready", 64'(ready), 64'd1);
    check("post_rst_we_n", 64'(sram_we_n), 64'd1);
    @(posedge clk);
    #1;

    run_access(1'b1, 1'b0, 32'd1028, 32'h0, FULL_LAT, 18'd2, 18'd3, 32'h1111_6666, 1'b0);

    check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    check("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
